// File: rtl/tm_pkg.sv
// tm_pkg: shared types and helpers for the multi-symbol Turing machine core.
//   move_t      - 2-bit move field of a rule (stay / left / right / halt)
//   status_t    - 2-bit run status reported on the status port
//   tm_state_t  - controller FSM states
//   pack_rule   - builds a {write_sym, move, next_state} rule word
//   move_blocked- true when a move would leave the tape
package tm_pkg;

  typedef enum logic [1:0] {
    STAY  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    HALT  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    HALTED = 2'b01,
    OOB    = 2'b10,
    LIMIT  = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOOKUP = 3'd2,
    EXEC   = 3'd3,
    PAUSE  = 3'd4,
    DONE   = 3'd5
  } tm_state_t;

  // Packs a rule word as {write_sym, move, next_state}; the caller truncates
  // the result to RULE_W bits.
  function automatic logic [31:0] pack_rule(input int unsigned state_w,
                                            input logic [15:0] write_sym,
                                            input move_t mv,
                                            input logic [15:0] next_state);
    logic [31:0] r;
    r = ({16'd0, write_sym} << (state_w + 32'd2)) |
        ({30'd0, mv} << state_w) |
        {16'd0, next_state};
    return r;
  endfunction

  // A left move at the first cell or a right move at the last cell is blocked.
  function automatic logic move_blocked(input move_t mv,
                                        input logic at_left,
                                        input logic at_right);
    return ((mv == LEFT) && at_left) || ((mv == RIGHT) && at_right);
  endfunction

endpackage

// File: rtl/tm_rule_table.sv
// tm_rule_table: 1R1W register array holding the transition rules.
//   clock  - system clock
//   reset  - synchronous active-low clear of every entry and the read register
//   we     - write strobe for waddr/wdata
//   waddr  - write address {state, symbol}
//   wdata  - rule word {write_sym, move, next_state}
//   raddr  - read address, sampled every cycle
//   rdata  - registered read data (one cycle after raddr)
module tm_rule_table #(
  parameter int AW = 5,
  parameter int DW = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Read-during-write to the same entry returns the old contents; the
  // controller never writes and looks up in the same cycle anyway.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/tm_multi_symbol_core.sv
// tm_multi_symbol_core: multi-symbol Turing machine datapath and controller.
//   clock, reset      - system clock, synchronous active-low reset
//   cfg_we/sel/addr/wdata - config port: sel=0 writes a rule, sel=1 a tape cell
//   start, start_head, step_mode, max_steps - run launch, sampled on start
//   step              - single-step advance while paused
//   rd_addr/rd_data   - combinational tape readback
//   busy, done, status - run progress and termination cause
//   cur_state, head, cur_sym, step_count - machine observation
// One machine step takes FETCH (read tape), LOOKUP (read rule), EXEC (commit).
module tm_multi_symbol_core
  import tm_pkg::*;
#(
  parameter int SYM_W      = 2,
  parameter int STATE_W    = 3,
  parameter int TAPE_DEPTH = 16,
  parameter int CNT_W      = 16,
  localparam int HEAD_W    = $clog2(TAPE_DEPTH),
  localparam int RULE_W    = SYM_W + 2 + STATE_W,
  localparam int RULE_AW   = STATE_W + SYM_W,
  localparam int CFG_AW    = (RULE_AW > HEAD_W) ? RULE_AW : HEAD_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [CFG_AW-1:0]  cfg_addr,
  input  logic [RULE_W-1:0]  cfg_wdata,
  input  logic               start,
  input  logic [HEAD_W-1:0]  start_head,
  input  logic               step_mode,
  input  logic               step,
  input  logic [CNT_W-1:0]   max_steps,
  input  logic [HEAD_W-1:0]  rd_addr,
  output logic [SYM_W-1:0]   rd_data,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status,
  output logic [STATE_W-1:0] cur_state,
  output logic [HEAD_W-1:0]  head,
  output logic [SYM_W-1:0]   cur_sym,
  output logic [CNT_W-1:0]   step_count
);

  localparam logic [HEAD_W:0]   DEPTH_EXT = (HEAD_W + 1)'(TAPE_DEPTH);
  localparam logic [HEAD_W-1:0] HEAD_MAX  = HEAD_W'(TAPE_DEPTH - 1);

  tm_state_t state, state_next;

  logic [SYM_W-1:0]  tape [TAPE_DEPTH];
  logic [RULE_W-1:0] rule_q;
  status_t           status_q;
  logic              step_mode_q;
  logic [CNT_W-1:0]  max_steps_q;

  logic              load_run;
  logic              cfg_ok;
  logic              is_halt;
  logic              is_oob;
  logic              is_limit;
  logic [CNT_W-1:0]  step_inc;
  logic [SYM_W-1:0]  rule_sym;
  move_t             rule_move;
  logic [STATE_W-1:0] rule_next;
  logic [HEAD_W-1:0] cfg_tape_idx;
  logic              cfg_tape_ok;
  logic              head_ok;
  logic              rd_ok;

  // Non power-of-two depths leave unused index codes; those are ignored.
  assign cfg_tape_idx = cfg_addr[HEAD_W-1:0];
  assign cfg_tape_ok  = {1'b0, cfg_tape_idx} < DEPTH_EXT;
  assign head_ok      = {1'b0, head} < DEPTH_EXT;
  assign rd_ok        = {1'b0, rd_addr} < DEPTH_EXT;

  assign rd_data = rd_ok ? tape[rd_addr] : '0;

  tm_rule_table #(
    .AW (RULE_AW),
    .DW (RULE_W)
  ) u_rules (
    .clock (clock),
    .reset (reset),
    .we    (cfg_ok && !cfg_sel),
    .waddr (cfg_addr[RULE_AW-1:0]),
    .wdata (cfg_wdata),
    .raddr ({cur_state, cur_sym}),
    .rdata (rule_q)
  );

  assign rule_sym  = rule_q[RULE_W-1 -: SYM_W];
  assign rule_move = move_t'(rule_q[STATE_W+1 -: 2]);
  assign rule_next = rule_q[STATE_W-1:0];

  // Step commit decode; halt outranks out-of-bounds, which outranks the limit.
  always_comb begin
    step_inc = (step_count == '1) ? step_count : step_count + CNT_W'(1);
    is_halt  = (rule_move == HALT);
    is_oob   = !is_halt && move_blocked(rule_move, head == '0, head == HEAD_MAX);
    is_limit = !is_halt && !is_oob && (max_steps_q != '0) && (step_inc == max_steps_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Config writes are only accepted while no run is in flight; a start in
  // PAUSE relaunches the run exactly as from IDLE.
  always_comb begin
    state_next = state;
    load_run   = 1'b0;
    cfg_ok     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        cfg_ok = cfg_we;
        if (start) begin
          load_run   = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH:  state_next = LOOKUP;
      LOOKUP: state_next = EXEC;
      EXEC: begin
        if (is_halt || is_oob || is_limit) begin
          state_next = DONE;
        end else if (step_mode_q) begin
          state_next = PAUSE;
        end else begin
          state_next = FETCH;
        end
      end
      PAUSE: begin
        if (start) begin
          load_run   = 1'b1;
          state_next = FETCH;
        end else if (step) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers and tape. The tape is written by the config port in
  // IDLE/DONE and by the step commit in EXEC, which never overlap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < TAPE_DEPTH; i++) begin
        tape[i] <= '0;
      end
      cur_state   <= '0;
      head        <= '0;
      cur_sym     <= '0;
      step_count  <= '0;
      status_q    <= NONE;
      step_mode_q <= 1'b0;
      max_steps_q <= '0;
    end else begin
      if (cfg_ok && cfg_sel && cfg_tape_ok) begin
        tape[cfg_tape_idx] <= cfg_wdata[SYM_W-1:0];
      end
      if (load_run) begin
        cur_state   <= '0;
        head        <= start_head;
        step_count  <= '0;
        status_q    <= NONE;
        step_mode_q <= step_mode;
        max_steps_q <= max_steps;
      end else if (state == FETCH) begin
        cur_sym <= head_ok ? tape[head] : '0;
      end else if (state == EXEC) begin
        if (head_ok) begin
          tape[head] <= rule_sym;
        end
        cur_state  <= rule_next;
        step_count <= step_inc;
        if (is_halt) begin
          status_q <= HALTED;
        end else if (is_oob) begin
          status_q <= OOB;
        end else begin
          if (rule_move == LEFT) begin
            head <= head - HEAD_W'(1);
          end else if (rule_move == RIGHT) begin
            head <= head + HEAD_W'(1);
          end
          if (is_limit) begin
            status_q <= LIMIT;
          end
        end
      end
    end
  end

  assign busy   = (state == FETCH) || (state == LOOKUP) || (state == EXEC) || (state == PAUSE);
  assign done   = (state == DONE);
  assign status = status_q;

endmodule

// File: tb/tb_tm_multi_symbol_core.sv
// tb_tm_multi_symbol_core: directed self-checking bench for tm_multi_symbol_core
// with default parameters (SYM_W=2, STATE_W=3, TAPE_DEPTH=16, CNT_W=16).
module tb_tm_multi_symbol_core;

  logic        clock;
  logic        reset;
  logic        cfg_we;
  logic        cfg_sel;
  logic [4:0]  cfg_addr;
  logic [6:0]  cfg_wdata;
  logic        start;
  logic [3:0]  start_head;
  logic        step_mode;
  logic        step;
  logic [15:0] max_steps;
  logic [3:0]  rd_addr;
  logic [1:0]  rd_data;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [2:0]  cur_state;
  logic [3:0]  head;
  logic [1:0]  cur_sym;
  logic [15:0] step_count;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] M_STAY = 2'b00, M_LEFT = 2'b01, M_RIGHT = 2'b10, M_HALT = 2'b11;

  tm_multi_symbol_core dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .start      (start),
    .start_head (start_head),
    .step_mode  (step_mode),
    .step       (step),
    .max_steps  (max_steps),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .cur_state  (cur_state),
    .head       (head),
    .cur_sym    (cur_sym),
    .step_count (step_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic cfg_write(input logic sel, input logic [4:0] addr, input logic [6:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rule_write(input logic [2:0] st, input logic [1:0] sym,
                            input logic [1:0] ws, input logic [1:0] mv, input logic [2:0] ns);
    cfg_write(1'b0, {st, sym}, {ws, mv, ns});
  endtask

  task automatic tape_write(input logic [3:0] idx, input logic [1:0] sym);
    cfg_write(1'b1, {1'b0, idx}, {5'd0, sym});
  endtask

  task automatic read_tape(input logic [3:0] idx, output logic [1:0] sym);
    rd_addr = idx;
    #1;
    sym = rd_data;
  endtask

  task automatic do_start(input logic [3:0] h, input logic mode, input logic [15:0] lim);
    start      = 1'b1;
    start_head = h;
    step_mode  = mode;
    max_steps  = lim;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 500) begin
      tick();
      cycles++;
    end
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] s;
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    checks++; if (status !== 2'b00) begin errors++; $display("[TB] FAIL reset_status: got %0d expected 0", status); end
    checks++; if (cur_state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", cur_state); end
    checks++; if (head !== 4'd0) begin errors++; $display("[TB] FAIL reset_head: got %0d expected 0", head); end
    checks++; if (cur_sym !== 2'd0) begin errors++; $display("[TB] FAIL reset_cur_sym: got %0d expected 0", cur_sym); end
    checks++; if (step_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_step_count: got %0d expected 0", step_count); end
    for (int i = 0; i < 16; i++) begin
      read_tape(4'(i), s);
      checks++; if (s !== 2'd0) begin errors++; $display("[TB] FAIL reset_tape[%0d]: got %0d expected 0", i, s); end
    end
  endtask

  // Little-endian increment of 0b0011 -> 0b0100 using states 0,1 and halt into 2.
  task automatic test_binary_increment();
    logic [1:0] s;
    logic [1:0] exp_tape [4];
    int cycles;
    exp_tape = '{2'd0, 2'd0, 2'd1, 2'd0};
    do_reset();
    rule_write(3'd0, 2'd1, 2'd0, M_RIGHT, 3'd0);
    rule_write(3'd0, 2'd0, 2'd1, M_STAY,  3'd1);
    rule_write(3'd1, 2'd1, 2'd1, M_HALT,  3'd2);
    rule_write(3'd1, 2'd0, 2'd0, M_HALT,  3'd2);
    tape_write(4'd0, 2'd1);
    tape_write(4'd1, 2'd1);
    do_start(4'd0, 1'b0, 16'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL inc_busy_after_start: got %0b expected 1", busy); end
    wait_done(cycles);
    checks++; if (cycles !== 12) begin errors++; $display("[TB] FAIL inc_latency: got %0d expected 12", cycles); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL inc_done: got %0b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL inc_busy: got %0b expected 0", busy); end
    checks++; if (status !== 2'b01) begin errors++; $display("[TB] FAIL inc_status: got %0d expected 1", status); end
    checks++; if (step_count !== 16'd4) begin errors++; $display("[TB] FAIL inc_step_count: got %0d expected 4", step_count); end
    checks++; if (head !== 4'd2) begin errors++; $display("[TB] FAIL inc_head: got %0d expected 2", head); end
    checks++; if (cur_state !== 3'd2) begin errors++; $display("[TB] FAIL inc_state: got %0d expected 2", cur_state); end
    for (int i = 0; i < 4; i++) begin
      read_tape(4'(i), s);
      checks++; if (s !== exp_tape[i]) begin errors++; $display("[TB] FAIL inc_tape[%0d]: got %0d expected %0d", i, s, exp_tape[i]); end
    end
  endtask

  task automatic test_oob_left();
    logic [1:0] s;
    int cycles;
    do_reset();
    rule_write(3'd0, 2'd0, 2'd3, M_LEFT, 3'd1);
    do_start(4'd0, 1'b0, 16'd0);
    wait_done(cycles);
    read_tape(4'd0, s);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL oobl_done: got %0b expected 1", done); end
    checks++; if (status !== 2'b10) begin errors++; $display("[TB] FAIL oobl_status: got %0d expected 2", status); end
    checks++; if (head !== 4'd0) begin errors++; $display("[TB] FAIL oobl_head: got %0d expected 0", head); end
    checks++; if (step_count !== 16'd1) begin errors++; $display("[TB] FAIL oobl_step_count: got %0d expected 1", step_count); end
    checks++; if (cur_state !== 3'd1) begin errors++; $display("[TB] FAIL oobl_state: got %0d expected 1", cur_state); end
    checks++; if (s !== 2'd3) begin errors++; $display("[TB] FAIL oobl_tape0: got %0d expected 3", s); end
  endtask

  // Bounces between cells 5 and 6 until the 5-step limit trips.
  task automatic test_step_limit();
    int late_low;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rule_write(3'd0, 2'(k), 2'd2, M_RIGHT, 3'd1);
      rule_write(3'd1, 2'(k), 2'd2, M_LEFT,  3'd0);
    end
    do_start(4'd5, 1'b0, 16'd5);
    late_low = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (busy !== 1'b1) late_low++;
    end
    checks++; if (late_low !== 0) begin errors++; $display("[TB] FAIL limit_busy_held: got %0d low cycles expected 0", late_low); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL limit_busy_fall15: got %0b expected 0", busy); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL limit_done: got %0b expected 1", done); end
    checks++; if (status !== 2'b11) begin errors++; $display("[TB] FAIL limit_status: got %0d expected 3", status); end
    checks++; if (step_count !== 16'd5) begin errors++; $display("[TB] FAIL limit_step_count: got %0d expected 5", step_count); end
    checks++; if (head !== 4'd6) begin errors++; $display("[TB] FAIL limit_head: got %0d expected 6", head); end
    checks++; if (cur_state !== 3'd1) begin errors++; $display("[TB] FAIL limit_state: got %0d expected 1", cur_state); end
  endtask

  // First step runs on start, then one step per pulse; config writes while
  // paused (a tape cell and a halting rule) must have no effect.
  task automatic test_step_mode();
    logic [1:0] s;
    do_reset();
    rule_write(3'd0, 2'd0, 2'd1, M_RIGHT, 3'd0);
    do_start(4'd0, 1'b1, 16'd0);
    repeat (10) tick();
    checks++; if (step_count !== 16'd1) begin errors++; $display("[TB] FAIL sm_count1: got %0d expected 1", step_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL sm_busy1: got %0b expected 1", busy); end
    pulse_step();
    repeat (9) tick();
    checks++; if (step_count !== 16'd2) begin errors++; $display("[TB] FAIL sm_count2: got %0d expected 2", step_count); end
    checks++; if (head !== 4'd2) begin errors++; $display("[TB] FAIL sm_head2: got %0d expected 2", head); end
    pulse_step();
    repeat (9) tick();
    checks++; if (step_count !== 16'd3) begin errors++; $display("[TB] FAIL sm_count3: got %0d expected 3", step_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL sm_busy3: got %0b expected 1", busy); end
    tape_write(4'd10, 2'd3);
    rule_write(3'd0, 2'd0, 2'd2, M_HALT, 3'd4);
    read_tape(4'd10, s);
    checks++; if (s !== 2'd0) begin errors++; $display("[TB] FAIL sm_pause_cfg_tape: got %0d expected 0", s); end
    pulse_step();
    repeat (9) tick();
    checks++; if (step_count !== 16'd4) begin errors++; $display("[TB] FAIL sm_count4: got %0d expected 4", step_count); end
    checks++; if (status !== 2'b00) begin errors++; $display("[TB] FAIL sm_pause_cfg_rule: got %0d expected 0", status); end
    checks++; if (head !== 4'd4) begin errors++; $display("[TB] FAIL sm_head4: got %0d expected 4", head); end
    read_tape(4'd3, s);
    checks++; if (s !== 2'd1) begin errors++; $display("[TB] FAIL sm_tape3: got %0d expected 1", s); end
  endtask

  // Reset sampled on the EXEC edge of the first step aborts the commit and
  // clears both arrays; the cleared rule 0 then just stays in place.
  task automatic test_reset_mid_run();
    logic [1:0] s;
    int cycles;
    do_reset();
    rule_write(3'd0, 2'd0, 2'd2, M_RIGHT, 3'd1);
    tape_write(4'd7, 2'd3);
    do_start(4'd5, 1'b0, 16'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %0b expected 0", busy); end
    checks++; if (step_count !== 16'd0) begin errors++; $display("[TB] FAIL rmid_step_count: got %0d expected 0", step_count); end
    checks++; if (head !== 4'd0) begin errors++; $display("[TB] FAIL rmid_head: got %0d expected 0", head); end
    read_tape(4'd5, s);
    checks++; if (s !== 2'd0) begin errors++; $display("[TB] FAIL rmid_tape5: got %0d expected 0", s); end
    read_tape(4'd7, s);
    checks++; if (s !== 2'd0) begin errors++; $display("[TB] FAIL rmid_tape7: got %0d expected 0", s); end
    do_start(4'd3, 1'b0, 16'd2);
    wait_done(cycles);
    checks++; if (status !== 2'b11) begin errors++; $display("[TB] FAIL rmid_rule_cleared_status: got %0d expected 3", status); end
    checks++; if (head !== 4'd3) begin errors++; $display("[TB] FAIL rmid_rule_cleared_head: got %0d expected 3", head); end
    checks++; if (cur_state !== 3'd0) begin errors++; $display("[TB] FAIL rmid_rule_cleared_state: got %0d expected 0", cur_state); end
  endtask

  // Right move at the last cell; also starts straight from DONE.
  task automatic test_right_edge();
    logic [1:0] s;
    int cycles;
    rule_write(3'd0, 2'd0, 2'd1, M_RIGHT, 3'd2);
    do_start(4'd15, 1'b0, 16'd0);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL redge_done_cleared: got %0b expected 0", done); end
    wait_done(cycles);
    read_tape(4'd15, s);
    checks++; if (status !== 2'b10) begin errors++; $display("[TB] FAIL redge_status: got %0d expected 2", status); end
    checks++; if (head !== 4'd15) begin errors++; $display("[TB] FAIL redge_head: got %0d expected 15", head); end
    checks++; if (step_count !== 16'd1) begin errors++; $display("[TB] FAIL redge_step_count: got %0d expected 1", step_count); end
    checks++; if (cur_state !== 3'd2) begin errors++; $display("[TB] FAIL redge_state: got %0d expected 2", cur_state); end
    checks++; if (s !== 2'd1) begin errors++; $display("[TB] FAIL redge_tape15: got %0d expected 1", s); end
  endtask

  initial begin
    reset      = 1'b0;
    cfg_we     = 1'b0;
    cfg_sel    = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    start      = 1'b0;
    start_head = '0;
    step_mode  = 1'b0;
    step       = 1'b0;
    max_steps  = '0;
    rd_addr    = '0;
    test_reset();
    test_binary_increment();
    test_oob_left();
    test_step_limit();
    test_step_mode();
    test_reset_mid_run();
    test_right_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tm_multi_symbol_core.md
Name: tm_multi_symbol_core

Overview:
- Parametrised successor to the single-bit tape Turing machine datapath/FSM.
- Supports a multi-bit symbol alphabet, a configurable state count and a register-array tape of configurable depth.
- Rule table and tape are loaded over a shared config port, then the block runs either free-running or in single-step mode.
- Status reporting covers halt, tape boundary violation and step limit; sits between the board I/O glue and the display shifter.

Parameters:
SYM_W, 2, bits per tape symbol; blank symbol is 0
STATE_W, 3, bits of machine state; start state is always 0
TAPE_DEPTH, 16, number of tape cells (power of two not required, >= 2)
CNT_W, 16, width of step counter and step limit
(derived) HEAD_W = $clog2(TAPE_DEPTH); RULE_W = SYM_W+2+STATE_W; RULE_AW = STATE_W+SYM_W; CFG_AW = max(RULE_AW, HEAD_W)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 on a rising edge resets)
cfg_we  in  1  config write strobe
cfg_sel  in  1  0 = rule table, 1 = tape cell
cfg_addr  in  CFG_AW  rule addr {state,symbol} or tape index (upper bits ignored as needed)
cfg_wdata  in  RULE_W  rule {write_sym, move, next_state}; tape uses low SYM_W bits
start  in  1  pulse: begin run from state 0 at start_head
start_head  in  HEAD_W  initial head position, sampled on start
step_mode  in  1  1 = single-step, sampled on start
step  in  1  pulse: advance one step while paused
max_steps  in  CNT_W  step limit, sampled on start; 0 = unlimited
rd_addr  in  HEAD_W  tape readback index
rd_data  out  SYM_W  combinational tape[rd_addr]
busy  out  1  run in progress (incl. paused)
done  out  1  run finished, held until next start/reset
status  out  2  00 none, 01 halted, 10 out of bounds, 11 step limit
cur_state  out  STATE_W  machine state
head  out  HEAD_W  head position
cur_sym  out  SYM_W  symbol latched at last FETCH
step_count  out  CNT_W  steps executed this run

Behaviour:
- Reset: FSM=IDLE; busy=0, done=0, status=00, cur_state=0, head=0, cur_sym=0, step_count=0; tape cells and rule table are cleared to 0 (rule 0 = write 0, stay, state 0).
- Move encoding: 00 stay, 01 left (head-1), 10 right (head+1), 11 halt.
- States: IDLE, FETCH, LOOKUP, EXEC, PAUSE, DONE.
- IDLE/DONE: cfg_we writes the selected array on the next edge; cfg_we in any other state is ignored. On start: cur_state<=0, head<=start_head, step_count<=0, status<=00, done<=0, busy<=1, go to FETCH. If start and cfg_we assert together, the config write happens and start is honoured.
- FETCH: cur_sym<=tape[head]; go to LOOKUP.
- LOOKUP: rule_q<=rule[{cur_state,cur_sym}]; go to EXEC.
- EXEC (step commit, single cycle):
  - Always: tape[head]<=write_sym, cur_state<=next_state, step_count+1.
  - move=11: status=01, go to DONE.
  - Left at head==0, or right at head==TAPE_DEPTH-1: write commits, head unchanged, status=10, go to DONE.
  - Otherwise head updates, then:
    - max_steps!=0 and new step_count==max_steps: status=11, go to DONE.
    - else step_mode: go to PAUSE; else go to FETCH.
- Step latency: 3 cycles per step in run mode.
- PAUSE: wait for step, then go to FETCH. start in PAUSE restarts the run as from IDLE.
- DONE: busy=0, done=1; outputs hold until start or reset.
- Priority when several conditions hit in EXEC: halt > out of bounds > step limit.
- step_count saturates at all-ones and does not wrap.
- start while in FETCH/LOOKUP/EXEC is ignored.
- reset low mid-run aborts on that edge to reset values, including array clear.

Decomposition:
- Package tm_pkg: move_t enum (STAY, LEFT, RIGHT, HALT), status_t enum (NONE, HALTED, OOB, LIMIT), fsm state enum, rule struct packing helper.
- Sub-module: tm_rule_table (1R1W register array with synchronous read and synchronous clear).
- Tape stays inline because it needs the combinational rd_data port.

Test Plan:
- Reset then readback: every tape cell reads 0, all outputs at reset values, busy=0.
- Binary increment with SYM_W=2, 3-state rule set: tape 0..3 = 1,1,0,0, start_head=0 -> halts, status=01, tape = 0,0,1,0.
- Head at 0 with rule move=LEFT -> one step, tape[0] written, head=0, status=10, step_count=1, done=1.
- Infinite right/left bouncer with max_steps=5 -> status=11, step_count=5, busy falls exactly 15 cycles after start.
- step_mode=1: 3 step pulses spaced 10 cycles apart -> step_count goes 1,2,3 and busy stays 1; cfg_we during PAUSE leaves tape unchanged.
- reset low during EXEC -> next cycle state=IDLE, arrays cleared; start with start_head=TAPE_DEPTH-1 and move RIGHT -> status=10.
